// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Main sequencer for the multicycle RV32I core. It steps each instruction
//   through fetch, decode, execute, memory and writeback. It drives the
//   datapath selects and write enables, and the 2-bit alu_op class that goes
//   to the ALU decoder (00 add, 01 sub, 10 funct-decoded). It also counts
//   retired instructions and traps on unsupported encodings.
//
// Optional build macro: RVS_MEM_WAIT_EN
//   Adds a mem_ready input. FETCH, MEMREAD and MEMWRITE then hold until
//   mem_ready=1. Without the macro, each of these states lasts one cycle.
//
// Ports:
//   clk, reset        single clock; synchronous active-high reset
//   opcode, funct3    instruction fields from the instruction register
//   zero              ALU zero flag, used for the beq branch decision
//   mem_ready         memory handshake (RVS_MEM_WAIT_EN builds only)
//   pc_write, adr_src, mem_write, ir_write, result_src,
//   alu_src_a, alu_src_b, reg_write, alu_op
//                     datapath controls
//   illegal           high while in TRAP
//   state             current state code, for debug
//   instret           retired-instruction counter (wraps)
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | read instr at PC, PC <= PC+4
// DECODE   | read regs, compute branch/jump target in ALU
// MEMADR   | compute load/store address
// MEMREAD  | read data memory
// MEMWB    | write load data to register file
// MEMWRITE | write data memory
// EXECR    | R-type ALU op
// ALUWB    | write ALU result to register file
// EXECI    | I-type ALU op
// JAL      | PC <= target, ALU computes link address
// BEQ      | compare; PC <= target when equal
// TRAP     | unsupported instruction, parked until reset
module multicycle_control_fsm #(
    parameter int STATE_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               zero,
`ifdef RVS_MEM_WAIT_EN
    input  logic               mem_ready,
`endif
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               reg_write,
    output logic [1:0]         alu_op,
    output logic               illegal,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t state_q, state_d;
    logic   mem_ok;
    logic   retire;
    logic   pc_write_c, ir_write_c, mem_write_c, reg_write_c;

`ifdef RVS_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    // MEMWRITE only retires on the edge that actually accepts the write.
    assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                    (state_q == S_BEQ)   || ((state_q == S_MEMWRITE) && mem_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = S_TRAP;
        pc_write_c  = 1'b0;
        adr_src     = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        reg_write_c = 1'b0;
        alu_op      = 2'b00;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_c = mem_ok;
                pc_write_c = mem_ok;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                state_d    = mem_ok ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    7'b0000011: state_d = (funct3 == 3'b010) ? S_MEMADR : S_TRAP;
                    7'b0100011: state_d = (funct3 == 3'b010) ? S_MEMADR : S_TRAP;
                    7'b0110011: state_d = S_EXECR;
                    7'b0010011: state_d = S_EXECI;
                    7'b1101111: state_d = S_JAL;
                    7'b1100011: state_d = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
                    default:    state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                // Only lw and sw reach here, so bit 5 alone separates them.
                state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = mem_ok ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                state_d     = mem_ok ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_write_c = zero;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
                state_d = S_TRAP;
            end
            default: state_d = S_TRAP;
        endcase
    end

    // Gate the enables with reset so that nothing is written in the reset cycle.
    assign pc_write  = pc_write_c  & ~reset;
    assign ir_write  = ir_write_c  & ~reset;
    assign mem_write = mem_write_c & ~reset;
    assign reg_write = reg_write_c & ~reset;

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
    logic [3:0]  state;
    logic [31:0] instret;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_instret = 0;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
`ifdef RVS_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .reg_write(reg_write), .alu_op(alu_op),
        .illegal(illegal), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    // Runs one legal instruction. It starts mid-cycle in FETCH and ends
    // mid-cycle in the next FETCH. The expected state walk and the
    // per-instruction enable totals come from the instruction class.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z);
        int path[$];
        int exp_rw, exp_mw, exp_pw, rw, mw, pw, iw;
        logic [1:0] exp_aop, aop_seen;
        bit path_ok;
        bit is_lw;
        rw = 0; mw = 0; pw = 0; iw = 0; path_ok = 1; aop_seen = 2'bxx;
        is_lw = 0;
        if (op == 7'b0000011) begin
            path = '{0,1,2,3,4};  exp_rw = 1; exp_mw = 0; exp_pw = 1; exp_aop = 2'b00; is_lw = 1;
        end else if (op == 7'b0100011) begin
            path = '{0,1,2,5};    exp_rw = 0; exp_mw = 1; exp_pw = 1; exp_aop = 2'b00;
        end else if (op == 7'b0110011) begin
            path = '{0,1,6,7};    exp_rw = 1; exp_mw = 0; exp_pw = 1; exp_aop = 2'b10;
        end else if (op == 7'b0010011) begin
            path = '{0,1,8,7};    exp_rw = 1; exp_mw = 0; exp_pw = 1; exp_aop = 2'b10;
        end else if (op == 7'b1101111) begin
            path = '{0,1,9,7};    exp_rw = 1; exp_mw = 0; exp_pw = 2; exp_aop = 2'b00;
        end else begin
            path = '{0,1,10};     exp_rw = 0; exp_mw = 0; exp_pw = 1 + int'(z); exp_aop = 2'b01;
        end
        opcode = op; funct3 = f3; zero = z;
        for (int i = 0; i < path.size(); i++) begin
            if (i > 0) @(negedge clk);
            if (int'(state) != path[i]) path_ok = 0;
            rw += int'(reg_write); mw += int'(mem_write);
            pw += int'(pc_write);  iw += int'(ir_write);
            if (i == 2) aop_seen = alu_op;
            if (is_lw && i == 4) begin
                tests++;
                if (result_src !== 2'b01) begin
                    fails++;
                    $display("FAIL memwb_result_src: got %b expected 01", result_src);
                end
            end
        end
        tests++;
        if (!path_ok) begin
            fails++;
            $display("FAIL state_path op=%b f3=%b: path differs from expected length %0d", op, f3, path.size());
        end
        tests++;
        if (rw != exp_rw || mw != exp_mw || pw != exp_pw || iw != 1) begin
            fails++;
            $display("FAIL enable_counts op=%b: rw=%0d mw=%0d pw=%0d iw=%0d expected %0d %0d %0d 1",
                     op, rw, mw, pw, iw, exp_rw, exp_mw, exp_pw);
        end
        tests++;
        if (aop_seen !== exp_aop) begin
            fails++;
            $display("FAIL alu_op op=%b: got %b expected %b", op, aop_seen, exp_aop);
        end
        @(negedge clk);
        model_instret++;
        tests++;
        if (state !== 4'd0 || instret !== model_instret) begin
            fails++;
            $display("FAIL retire op=%b: state=%0d instret=%0d expected 0 %0d", op, state, instret, model_instret);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({pc_write, ir_write, mem_write, reg_write} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_enables: got %b expected 0000", {pc_write, ir_write, mem_write, reg_write});
        end
        @(negedge clk);
        tests++;
        if (state !== 4'd0 || {pc_write, ir_write, mem_write, reg_write} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_hold: state=%0d en=%b expected 0 0000", state, {pc_write, ir_write, mem_write, reg_write});
        end
        reset = 1'b0;
        model_instret = 0;
        #1;
        tests++;
        if (state !== 4'd0 || pc_write !== 1'b1 || ir_write !== 1'b1 || instret !== 32'd0) begin
            fails++;
            $display("FAIL post_reset: state=%0d pc_write=%b ir_write=%b instret=%0d expected 0 1 1 0",
                     state, pc_write, ir_write, instret);
        end
    endtask

    task automatic test_add();
        run_instr(7'b0110011, 3'b000, 1'b0);
    endtask

    task automatic test_lw_sw();
        run_instr(7'b0000011, 3'b010, 1'b0);
        run_instr(7'b0100011, 3'b010, 1'b0);
    endtask

    task automatic test_beq();
        run_instr(7'b1100011, 3'b000, 1'b1);
        run_instr(7'b1100011, 3'b000, 1'b0);
    endtask

    task automatic test_trap(input logic [6:0] op, input logic [2:0] f3);
        opcode = op; funct3 = f3;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if (state !== 4'd11 || illegal !== 1'b1 || instret !== model_instret ||
                {pc_write, ir_write, mem_write, reg_write} !== 4'b0000) begin
                fails++;
                $display("FAIL trap_hold op=%b f3=%b: state=%0d illegal=%b instret=%0d en=%b expected 11 1 %0d 0000",
                         op, f3, state, illegal, instret, {pc_write, ir_write, mem_write, reg_write}, model_instret);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        model_instret = 0;
        tests++;
        if (state !== 4'd0 || illegal !== 1'b0 || instret !== 32'd0) begin
            fails++;
            $display("FAIL trap_reset: state=%0d illegal=%b instret=%0d expected 0 0 0", state, illegal, instret);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (pc_write !== 1'b1 || ir_write !== 1'b1) begin
            fails++;
            $display("FAIL trap_refetch: pc_write=%b ir_write=%b expected 1 1", pc_write, ir_write);
        end
    endtask

    task automatic test_reset_in_memwrite();
        opcode = 7'b0100011; funct3 = 3'b010;
        repeat (3) @(negedge clk);
        tests++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            fails++;
            $display("FAIL memwrite_reach: state=%0d mem_write=%b expected 5 1", state, mem_write);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (mem_write !== 1'b0) begin
            fails++;
            $display("FAIL memwrite_reset_gate: mem_write=%b expected 0", mem_write);
        end
        @(negedge clk);
        model_instret = 0;
        tests++;
        if (state !== 4'd0 || instret !== 32'd0 || mem_write !== 1'b0) begin
            fails++;
            $display("FAIL memwrite_reset_next: state=%0d instret=%0d mem_write=%b expected 0 0 0",
                     state, instret, mem_write);
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        for (int n = 0; n < 40; n++) begin
            int k;
            logic [2:0] f3;
            k = $urandom_range(0, 5);
            f3 = 3'($urandom);
            if (k <= 1) f3 = 3'b010;
            if (k == 5) f3 = 3'b000;
            run_instr(ops[k], f3, 1'($urandom));
        end
    endtask

`ifdef RVS_MEM_WAIT_EN
    task automatic test_mem_wait();
        opcode = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b0;
        #1;
        tests++;
        if (state !== 4'd0 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
            fails++;
            $display("FAIL fetch_wait: state=%0d ir_write=%b pc_write=%b expected 0 0 0", state, ir_write, pc_write);
        end
        @(negedge clk);
        tests++;
        if (state !== 4'd0) begin
            fails++;
            $display("FAIL fetch_hold: state=%0d expected 0", state);
        end
        mem_ready = 1'b1;
        #1;
        tests++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
            fails++;
            $display("FAIL fetch_ready: ir_write=%b pc_write=%b expected 1 1", ir_write, pc_write);
        end
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            tests++;
            if (state !== 4'd3) begin
                fails++;
                $display("FAIL memread_hold: state=%0d expected 3", state);
            end
        end
        mem_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (state !== 4'd4) begin
            fails++;
            $display("FAIL memread_exit: state=%0d expected 4", state);
        end
        @(negedge clk);
        model_instret++;
        tests++;
        if (state !== 4'd0 || instret !== model_instret) begin
            fails++;
            $display("FAIL wait_retire: state=%0d instret=%0d expected 0 %0d", state, instret, model_instret);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_lw_sw();
        test_beq();
        test_trap(7'b1110011, 3'b000);
        test_trap(7'b0000011, 3'b000);
        test_trap(7'b1100011, 3'b001);
        test_random();
        test_reset_in_memwrite();
        test_add();
`ifdef RVS_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main sequencer for the multicycle RV32I core variant.
- Walks each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath mux selects and write enables, and the 2-bit alu_op consumed by the downstream ALU decoder:
  - 00 = add
  - 01 = subtract
  - 10 = funct-decoded
- Also counts retired instructions and traps on unsupported opcodes.

Parameters:
- STATE_W, 4, width of the state register and of the debug state output.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  7  instr[6:0] from the instruction register.
- funct3  input  3  instr[14:12] from the instruction register.
- zero  input  1  ALU zero flag.
- pc_write  output  1  PC register enable.
- adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register.
- mem_write  output  1  data memory write enable.
- ir_write  output  1  instruction register and old-PC register enable.
- result_src  output  2  result mux: 00 = ALU out reg, 01 = read data reg, 10 = ALU result.
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1 reg.
- alu_src_b  output  2  ALU B select: 00 = rs2 reg, 01 = immediate, 10 = constant 4.
- reg_write  output  1  register file write enable.
- alu_op  output  2  ALU operation class to the ALU decoder.
- illegal  output  1  high while in TRAP.
- state  output  STATE_W  current state code, for debug.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Moore FSM: outputs decode from the state register, except pc_write in BEQ.
- Every output not listed for a state is 0.
- State encodings:

| State | Code | Outputs | Next state |
|---|---|---|---|
| FETCH | 0 | adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_write=1 | DECODE |
| DECODE | 1 | alu_src_a=01, alu_src_b=01, alu_op=00 | see below |
| MEMADR | 2 | alu_src_a=10, alu_src_b=01, alu_op=00 | lw to MEMREAD, sw to MEMWRITE |
| MEMREAD | 3 | adr_src=1, result_src=00 | MEMWB |
| MEMWB | 4 | result_src=01, reg_write=1 | FETCH |
| MEMWRITE | 5 | adr_src=1, result_src=00, mem_write=1 | FETCH |
| EXECR | 6 | alu_src_a=10, alu_src_b=00, alu_op=10 | ALUWB |
| ALUWB | 7 | result_src=00, reg_write=1 | FETCH |
| EXECI | 8 | alu_src_a=10, alu_src_b=01, alu_op=10 | ALUWB |
| JAL | 9 | alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 | ALUWB |
| BEQ | 10 | alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero | FETCH |
| TRAP | 11 | illegal=1, all enables 0 | TRAP until reset |

- DECODE next state, by opcode and funct3:
  - 0000011 with funct3=010 (lw): MEMADR.
  - 0100011 with funct3=010 (sw): MEMADR.
  - 0110011: EXECR.
  - 0010011: EXECI.
  - 1101111: JAL.
  - 1100011 with funct3=000: BEQ.
  - Anything else: TRAP.
- Unused codes 12-15 go to TRAP on the next edge.
- Latency in cycles:
  - lw: 5.
  - sw: 4.
  - R-type: 4.
  - I-type ALU: 4.
  - jal: 4.
  - beq: 3.
- Reset:
  - While reset=1, pc_write, ir_write, mem_write and reg_write are forced to 0 combinationally.
  - On an edge with reset=1: state goes to FETCH, instret goes to 0, illegal goes to 0 on the next cycle.
  - Reset mid-instruction abandons it; no partial write occurs after the reset edge.
- instret:
  - Increments by 1 on each edge leaving MEMWB, MEMWRITE, ALUWB or BEQ.
  - Wraps modulo 2^CNT_W.
  - Never increments in TRAP or while reset=1.
  - JAL retires via ALUWB and is counted once.
- A taken and a not-taken beq both count as retired.

Optional Feature:
- Macro: RVS_MEM_WAIT_EN.
- Defined:
  - Adds input port mem_ready (1 bit), placed after zero.
  - FETCH, MEMREAD and MEMWRITE hold until mem_ready=1.
  - In FETCH, ir_write and pc_write assert only in the mem_ready=1 cycle.
  - In MEMWRITE, mem_write asserts every cycle of the state; a write is accepted in the cycle mem_ready=1.
  - Transitions out of these states occur only on an edge with mem_ready=1.
  - Reset overrides waits.
- Undefined:
  - No mem_ready port.
  - Each of these states lasts exactly 1 cycle.

Test Plan:
- Reset for 2 cycles, then release:
  - state=0, pc_write/ir_write high in the first post-reset cycle.
  - instret=0.
  - During reset all enables are 0.
- add, opcode 0110011 funct3 000:
  - States 0,1,6,7.
  - alu_op=10 in EXECR.
  - reg_write=1 in ALUWB only.
  - instret 0 to 1 after 4 cycles.
- lw (0000011/010) then sw (0100011/010):
  - lw visits 0,1,2,3,4 (5 cycles) with result_src=01 in MEMWB.
  - sw visits 0,1,2,5 with mem_write=1 for exactly 1 cycle.
  - instret=2.
- beq, 1100011/000:
  - With zero=1: pc_write=1 in BEQ, alu_op=01.
  - Repeat with zero=0: pc_write=0.
  - Both increment instret.
- Illegal opcode 1110011:
  - DECODE goes to TRAP (11); illegal=1 and held for 10 cycles with no enables.
  - instret unchanged.
  - Reset returns to FETCH with illegal=0.
- Reset asserted in MEMWRITE:
  - mem_write=0 that cycle; next state FETCH.
  - With RVS_MEM_WAIT_EN: mem_ready=0 for 3 cycles in MEMREAD holds state 3, then exits to MEMWB on mem_ready=1.
